vga_timing_gen: RTL

//  Parametrised VGA raster timing generator: divides clk_100 down to a pixel-rate enable,

---
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides clk_100 into a pixel-rate enable, walks the horizontal/vertical
// raster counters, and decodes sync/blank with selectable polarity. The
// decoded timing can be delayed by a number of pixel ticks so it lines up
// with a downstream pixel pipeline.

module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int PIPE    = 0,
  parameter int XW      = 10,
  parameter int YW      = 10
) (
  input  logic          clk_100,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  // Divider width; a divide-by-one still needs a one-bit register.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS    = XW'(H_DISP);
  localparam logic [XW-1:0] HS_START = XW'(H_DISP + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_DISP + H_FP + H_SYNC - 1);

  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS    = YW'(V_DISP);
  localparam logic [YW-1:0] VS_START = YW'(V_DISP + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_DISP + V_FP + V_SYNC - 1);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  logic [DW-1:0] div;
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          h_last;
  logic          v_last;

  // Timing flags as seen at the output, before polarity is applied.
  logic          hs_out;
  logic          vs_out;
  logic          vid_out;

  // Decode of the current counter values.
  logic          hs_now;
  logic          vs_now;
  logic          vid_now;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // Reset gating keeps the tick quiet while reset is held even when the
  // divider is bypassed (CLK_DIV = 1).
  assign p_tick = enable && !reset && (div == DIV_LAST);

  // Pixel-rate divider; holds its phase while enable is low.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Raster counters: h every pixel tick, v once per horizontal wrap.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v <= '0;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign hs_now  = (h >= HS_START) && (h <= HS_END);
  assign vs_now  = (v >= VS_START) && (v <= VS_END);
  assign vid_now = (h < H_VIS) && (v < V_VIS);

  generate
    if (PIPE == 0) begin : g_direct
      logic hs_d;
      logic vs_d;
      logic vid_d;

      // Register the decode one clk_100 after the counters so the
      // outputs come straight from flops and cannot glitch.
      always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
          hs_d  <= 1'b0;
          vs_d  <= 1'b0;
          vid_d <= 1'b0;
        end else begin
          hs_d  <= hs_now;
          vs_d  <= vs_now;
          vid_d <= vid_now;
        end
      end

      assign hs_out  = hs_d;
      assign vs_out  = vs_d;
      assign vid_out = vid_d;
    end else begin : g_delay
      // Each entry is {hs, vs, vid}; entry 0 is one pixel behind the counters.
      logic [2:0] stage [PIPE];

      // Delay line advanced on pixel ticks only, so the lag is exactly
      // PIPE pixels independent of CLK_DIV; filled with inactive values on reset.
      always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE; i++) begin
            stage[i] <= 3'b000;
          end
        end else if (p_tick) begin
          stage[0] <= {hs_now, vs_now, vid_now};
          for (int i = 1; i < PIPE; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign hs_out  = stage[PIPE-1][2];
      assign vs_out  = stage[PIPE-1][1];
      assign vid_out = stage[PIPE-1][0];
    end
  endgenerate

  assign hsync    = hs_out ? HS_LVL : ~HS_LVL;
  assign vsync    = vs_out ? VS_LVL : ~VS_LVL;
  assign video_on = vid_out;

  assign line_start  = p_tick && h_last;
  assign frame_start = line_start && v_last;

  assign pixel_x = h;
  assign pixel_y = v;

endmodule
